// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_e    : 3-bit decoded HI/LO operation code from the execute stage
//   state_e : iteration FSM states
//   MUL_ITERS / DIV_ITERS : fixed iteration counts (radix-256 mul, radix-2 div)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OpNone  = 3'd0,
    OpMult  = 3'd1,
    OpMultu = 3'd2,
    OpDiv   = 3'd3,
    OpDivu  = 3'd4,
    OpMthi  = 3'd5,
    OpMtlo  = 3'd6,
    OpMul   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMulIter = 2'd1,
    StDivIter = 2'd2,
    StFix     = 2'd3
  } state_e;

  localparam int unsigned MUL_ITERS = 4;
  localparam int unsigned DIV_ITERS = 32;

  function automatic logic op_is_div(op_e op);
    return (op == OpDiv) || (op == OpDivu);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage (master) and muldiv_unit (slave).
//   i_start  : request valid        i_op : operation code (muldiv_pkg::op_e encoding)
//   i_a/i_b  : rs/rt operands       i_cancel : exception flush, aborts work in flight
//   o_busy   : operation in flight  o_done   : one-cycle commit pulse
//   o_hi/o_lo: architectural HI/LO
interface muldiv_if;
  logic        i_start;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        i_cancel;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  modport slave (
    input  i_start, i_op, i_a, i_b, i_cancel,
    output o_busy, o_done, o_hi, o_lo
  );

  modport master (
    output i_start, i_op, i_a, i_b, i_cancel,
    input  o_busy, o_done, o_hi, o_lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Combinational result correction applied in the FIX cycle.
//   i_raw  : unsigned magnitude result ({rem,quo} for divide, 64-bit product otherwise)
//   i_op   : operation being committed
//   i_sa/i_sb : operand sign bits (already zero for unsigned ops)
//   i_div0 : divisor was zero
//   o_hi/o_lo : values to commit to HI/LO
module muldiv_sign_fix
  import muldiv_pkg::*;
(
  input  logic [63:0] i_raw,
  input  op_e         i_op,
  input  logic        i_sa,
  input  logic        i_sb,
  input  logic        i_div0,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [63:0] w_prod_neg;

  assign w_prod_neg = -i_raw;

  always_comb begin
    o_hi = i_raw[63:32];
    o_lo = i_raw[31:0];
    if (op_is_div(i_op)) begin
      if (i_sa ^ i_sb) o_lo = -i_raw[31:0];
      // Remainder follows the dividend sign; for a zero divisor the remainder
      // magnitude is |A|, so this also restores Hi = A.
      if (i_sa) o_hi = -i_raw[63:32];
      if (i_div0) o_lo = 32'hFFFF_FFFF;
    end else if (i_sa ^ i_sb) begin
      o_hi = w_prod_neg[63:32];
      o_lo = w_prod_neg[31:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit owning the architectural HI/LO registers.
//   i_clk   : clock, all state changes on the rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : muldiv_if.slave request/response bundle
// Multiplies take 4 radix-256 iterations plus a FIX cycle; divides take 32
// restoring radix-2 iterations plus a FIX cycle. Done pulses the cycle after FIX.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst_n,
  muldiv_if.slave  bus
);

  state_e      r_state, w_state_nxt;
  logic [4:0]  r_cnt;
  op_e         r_op;
  logic        r_sa, r_sb, r_div0;
  logic [31:0] r_ma;   // |A|; during divide, shifts dividend out and quotient in
  logic [31:0] r_mb;   // |B|; during multiply, shifts right one byte per iteration
  logic [63:0] r_acc;
  logic [31:0] r_rem;
  logic        r_busy, r_done;
  logic [31:0] r_hi, r_lo;

  op_e         w_op;
  logic        w_accept, w_go_mul, w_go_div, w_signed;
  logic        w_last_mul, w_last_div;
  logic        w_commit, w_busy_nxt, w_hi_we;
  logic [31:0] w_a_mag, w_b_mag;
  logic [39:0] w_pp;
  logic [63:0] w_pp_sh;
  logic [32:0] w_prem;
  logic [33:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_nxt;
  logic [63:0] w_raw;
  logic [31:0] w_fix_hi, w_fix_lo;

  assign w_op     = op_e'(bus.i_op);
  assign w_accept = (r_state == StIdle) && bus.i_start && !bus.i_cancel;
  assign w_go_mul = w_accept && (w_op == OpMult || w_op == OpMultu || w_op == OpMul);
  assign w_go_div = w_accept && op_is_div(w_op);
  assign w_signed = (w_op == OpMult) || (w_op == OpDiv) || (w_op == OpMul);

  // 0x80000000 negates to itself, which read unsigned is exactly 2^31.
  assign w_a_mag = (w_signed && bus.i_a[31]) ? -bus.i_a : bus.i_a;
  assign w_b_mag = (w_signed && bus.i_b[31]) ? -bus.i_b : bus.i_b;

  assign w_last_mul = (r_cnt == 5'(MUL_ITERS - 1));
  assign w_last_div = (r_cnt == 5'(DIV_ITERS - 1));

  // Radix-256 partial product: |A| times the current low byte of |B|.
  assign w_pp    = {8'b0, r_ma} * {32'b0, r_mb[7:0]};
  assign w_pp_sh = {24'b0, w_pp} << {r_cnt[1:0], 3'b000};

  // Restoring divide step on a 33-bit partial remainder.
  assign w_prem    = {r_rem, r_ma[31]};
  assign w_diff    = {1'b0, w_prem} - {2'b0, r_mb};
  assign w_qbit    = ~w_diff[33];
  assign w_rem_nxt = w_qbit ? w_diff[31:0] : w_prem[31:0];

  assign w_raw = op_is_div(r_op) ? {r_rem, r_ma} : r_acc;

  muldiv_sign_fix u_sign_fix (
    .i_raw  (w_raw),
    .i_op   (r_op),
    .i_sa   (r_sa),
    .i_sb   (r_sb),
    .i_div0 (r_div0),
    .o_hi   (w_fix_hi),
    .o_lo   (w_fix_lo)
  );

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_go_mul)      w_state_nxt = StMulIter;
        else if (w_go_div) w_state_nxt = StDivIter;
      end
      StMulIter: if (w_last_mul) w_state_nxt = StFix;
      StDivIter: if (w_last_div) w_state_nxt = StFix;
      StFix:     w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
    if (r_state != StIdle && bus.i_cancel) w_state_nxt = StIdle;
  end

  // FSM outputs: commit only from FIX, and a cancel there wins over the commit.
  always_comb begin
    w_commit   = (r_state == StFix) && !bus.i_cancel;
    w_hi_we    = w_commit && (r_op != OpMul);
    w_busy_nxt = (w_state_nxt != StIdle);
  end

  // Datapath: operand latch and iteration registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_op   <= OpNone;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div0 <= 1'b0;
      r_ma   <= '0;
      r_mb   <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
    end else if (w_go_mul || w_go_div) begin
      r_cnt  <= '0;
      r_op   <= w_op;
      r_sa   <= w_signed && bus.i_a[31];
      r_sb   <= w_signed && bus.i_b[31];
      r_div0 <= (bus.i_b == 32'd0);
      r_ma   <= w_a_mag;
      r_mb   <= w_b_mag;
      r_acc  <= '0;
      r_rem  <= '0;
    end else if (r_state == StMulIter) begin
      r_cnt <= r_cnt + 5'd1;
      r_acc <= r_acc + w_pp_sh;
      r_mb  <= r_mb >> 8;
    end else if (r_state == StDivIter) begin
      r_cnt <= r_cnt + 5'd1;
      r_rem <= w_rem_nxt;
      r_ma  <= {r_ma[30:0], w_qbit};
    end
  end

  // Architectural HI/LO plus registered status
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_commit;
      if (w_hi_we) r_hi <= w_fix_hi;
      if (w_commit) r_lo <= w_fix_lo;
      if (w_accept && w_op == OpMthi) r_hi <= bus.i_a;
      if (w_accept && w_op == OpMtlo) r_lo <= bus.i_a;
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit. Inputs change on the falling
// edge, outputs are sampled on the falling edge; cycle N is the N-th cycle
// after the rising edge that accepted Start.
module tb_muldiv_unit;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  muldiv_if bus ();

  muldiv_unit u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.i_start  = 1'b0;
    bus.i_op     = 3'd0;
    bus.i_a      = $urandom;
    bus.i_b      = $urandom;
    bus.i_cancel = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge of the Done cycle so
  // the next request can issue back-to-back.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0, lo0;
    int bad;
    hi0 = bus.o_hi;
    lo0 = bus.o_lo;
    bad = 0;
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    @(posedge clk);
    #1;
    idle_inputs();  // scrambled operands must not affect the result
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0 || bus.o_hi !== hi0 || bus.o_lo !== lo0)
        bad++;
    end
    check({tag, ".busy_window"}, 64'(bad), 64'd0);
    @(negedge clk);
    check({tag, ".done"}, {63'd0, bus.o_done}, 64'd1);
    check({tag, ".busy_off"}, {63'd0, bus.o_busy}, 64'd0);
    check({tag, ".hi"}, {32'd0, bus.o_hi}, {32'd0, exp_hi});
    check({tag, ".lo"}, {32'd0, bus.o_lo}, {32'd0, exp_lo});
  endtask

  // MTHI/MTLO: value visible in cycle 1, Busy and Done stay low.
  task automatic move_to(input logic [2:0] op, input logic [31:0] a);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check(op == 3'd5 ? "mthi.val" : "mtlo.val",
          {32'd0, (op == 3'd5) ? bus.o_hi : bus.o_lo}, {32'd0, a});
    check("mt.busy_done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
  endtask

  initial begin
    int saw_done;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    check("rst.hi", {32'd0, bus.o_hi}, 64'd0);
    check("rst.lo", {32'd0, bus.o_lo}, 64'd0);
    check("rst.busy_done", {62'd0, bus.o_busy, bus.o_done}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    move_to(3'd5, 32'h0000_1234);
    run_op("mul", 3'd7, 32'd7, 32'd6, 5, 32'h0000_1234, 32'd42);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("divu0", 3'd4, 32'd100, 32'd0, 33, 32'd100, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000);
    run_op("div0_neg", 3'd3, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Op NONE with Start is ignored.
    bus.i_start = 1'b1;
    bus.i_op    = 3'd0;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("none.busy", {63'd0, bus.o_busy}, 64'd0);

    // Cancel mid-divide; a Start (MTHI) during Busy must be ignored too.
    move_to(3'd5, 32'd5);
    move_to(3'd6, 32'd5);
    bus.i_start = 1'b1;
    bus.i_op    = 3'd4;
    bus.i_a     = 32'd100;
    bus.i_b     = 32'd3;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (10) @(negedge clk);  // now in cycle 10
    bus.i_cancel = 1'b1;
    bus.i_start  = 1'b1;
    bus.i_op     = 3'd5;
    bus.i_a      = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("cancel.busy", {63'd0, bus.o_busy}, 64'd0);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.o_done === 1'b1) saw_done++;
      @(negedge clk);
    end
    check("cancel.no_done", 64'(saw_done), 64'd0);
    check("cancel.hi", {32'd0, bus.o_hi}, 64'd5);
    check("cancel.lo", {32'd0, bus.o_lo}, 64'd5);

    // Start together with Cancel in IDLE is dropped.
    bus.i_start  = 1'b1;
    bus.i_cancel = 1'b1;
    bus.i_op     = 3'd1;
    bus.i_a      = 32'd3;
    bus.i_b      = 32'd3;
    @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    check("start_cancel.busy", {63'd0, bus.o_busy}, 64'd0);
    saw_done = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.o_done === 1'b1) saw_done++;
      @(negedge clk);
    end
    check("start_cancel.no_done", 64'(saw_done), 64'd0);
    check("start_cancel.lo", {32'd0, bus.o_lo}, 64'd5);

    // Asynchronous reset in cycle 20 of a DIV.
    bus.i_start = 1'b1;
    bus.i_op    = 3'd3;
    bus.i_a     = 32'd1000;
    bus.i_b     = 32'd7;
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (20) @(negedge clk);
    check("pre_rst.busy", {63'd0, bus.o_busy}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst.busy", {63'd0, bus.o_busy}, 64'd0);
    check("async_rst.hilo", {bus.o_hi, bus.o_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.o_done === 1'b1 || bus.o_busy === 1'b1) saw_done++;
    end
    check("post_rst.quiet", 64'(saw_done), 64'd0);
    run_op("post_rst_mult", 3'd1, 32'd12, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFDC);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
